// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and its pixel consumers.
interface vga_timing_if #(
   parameter int unsigned POS_W = 11
) ();
   logic             run;
   logic             pix_ce;
   logic [POS_W-1:0] fetch_x;
   logic [POS_W-1:0] fetch_y;
   logic             fetch_valid;
   logic [POS_W-1:0] hpos;
   logic [POS_W-1:0] vpos;
   logic             hsync;
   logic             vsync;
   logic             display_on;
   logic             line_start;
   logic             frame_start;
   logic             active;

   modport master (
      input  run,
      output pix_ce, fetch_x, fetch_y, fetch_valid, hpos, vpos,
             hsync, vsync, display_on, line_start, frame_start, active
   );

   modport slave (
      output run,
      input  pix_ce, fetch_x, fetch_y, fetch_valid, hpos, vpos,
             hsync, vsync, display_on, line_start, frame_start, active
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster generator: pixel divider, look-ahead fetch counter,
// LEAD-deep output pipe and a run/stop FSM that halts on frame boundaries.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_BOTTOM  = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_TOP     = 33,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned PIX_DIV   = 1,
   parameter int unsigned LEAD      = 2,
   parameter int unsigned POS_W     = 11
) (
   input logic         clk,
   input logic         reset,
   vga_timing_if.master vga
);

   localparam int unsigned H_MAX    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
   localparam int unsigned V_MAX    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_DISPLAY + V_BOTTOM;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
   localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int unsigned PIPE_N   = (LEAD > 0) ? LEAD : 1;

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic             valid;
   } pix_t;

   logic [DIV_W-1:0] div_cnt;
   logic             pix_ce;
   state_t           state, state_nx;
   logic [POS_W-1:0] x_q, y_q, x_nx, y_nx;
   logic             wrap_x, wrap_frame;
   pix_t             entry_in, src;
   pix_t             pipe [PIPE_N];
   logic             pipe_busy;

   logic             fetch_valid_q;
   logic [POS_W-1:0] hpos_q, vpos_q, hpos_d, vpos_d;
   logic             hsync_q, vsync_q, hsync_d, vsync_d;
   logic             de_q, ls_q, fs_q, de_d, ls_d, fs_d;
   logic             active_q;

   // Free-running pixel divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (div_cnt == DIV_W'(PIX_DIV - 1))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   assign pix_ce = !reset && (div_cnt == DIV_W'(PIX_DIV - 1));

   // Next raster position and run/stop transitions
   always_comb begin
      state_nx   = state;
      x_nx       = x_q;
      y_nx       = y_q;
      wrap_x     = (x_q == POS_W'(H_MAX));
      wrap_frame = wrap_x && (y_q == POS_W'(V_MAX));
      if (state != IDLE) begin
         x_nx = wrap_x ? '0 : x_q + POS_W'(1);
         if (wrap_x)
            y_nx = (y_q == POS_W'(V_MAX)) ? '0 : y_q + POS_W'(1);
      end
      case (state)
         IDLE:     if (vga.run) state_nx = RUN;
         RUN:      if (!vga.run) state_nx = STOPPING;
         STOPPING: begin
            if (vga.run)
               state_nx = RUN;
            else if (wrap_frame)
               state_nx = IDLE;
         end
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      entry_in.x     = x_nx;
      entry_in.y     = y_nx;
      entry_in.valid = (state_nx != IDLE);
      src            = (LEAD == 0) ? entry_in : pipe[PIPE_N-1];
   end

   // Anything still in flight keeps the generator reported as active
   always_comb begin
      pipe_busy = 1'b0;
      if (LEAD != 0)
         for (int i = 0; i < PIPE_N; i++)
            pipe_busy = pipe_busy | pipe[i].valid;
   end

   always_comb begin
      hpos_d  = '0;
      vpos_d  = '0;
      hsync_d = ~HS_POL;
      vsync_d = ~VS_POL;
      de_d    = 1'b0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (src.valid) begin
         hpos_d = src.x;
         vpos_d = src.y;
         if (src.x >= POS_W'(HS_START) && src.x <= POS_W'(HS_END))
            hsync_d = HS_POL;
         if (src.y >= POS_W'(VS_START) && src.y <= POS_W'(VS_END))
            vsync_d = VS_POL;
         de_d = (src.x < POS_W'(H_DISPLAY)) && (src.y < POS_W'(V_DISPLAY));
         ls_d = (src.x == '0);
         fs_d = (src.x == '0) && (src.y == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         fetch_valid_q <= 1'b0;
         for (int i = 0; i < PIPE_N; i++)
            pipe[i] <= '0;
         hpos_q        <= '0;
         vpos_q        <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         de_q          <= 1'b0;
         ls_q          <= 1'b0;
         fs_q          <= 1'b0;
         active_q      <= 1'b0;
      end else if (pix_ce) begin
         state         <= state_nx;
         x_q           <= x_nx;
         y_q           <= y_nx;
         fetch_valid_q <= (state_nx != IDLE) && (x_nx < POS_W'(H_DISPLAY)) &&
                          (y_nx < POS_W'(V_DISPLAY));
         pipe[0]       <= entry_in;
         for (int i = 1; i < PIPE_N; i++)
            pipe[i] <= pipe[i-1];
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         ls_q          <= ls_d;
         fs_q          <= fs_d;
         active_q      <= (state_nx != IDLE) || pipe_busy;
      end
   end

   assign vga.pix_ce      = pix_ce;
   assign vga.fetch_x     = x_q;
   assign vga.fetch_y     = y_q;
   assign vga.fetch_valid = fetch_valid_q;
   assign vga.hpos        = hpos_q;
   assign vga.vpos        = vpos_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.display_on  = de_q;
   assign vga.line_start  = ls_q;
   assign vga.frame_start = fs_q;
   assign vga.active      = active_q;

endmodule
